decode_ctrl_stage: RTL and testbench
====================================

DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 Parameter: ENABLE_M, 1, decode RV32M (MUL/DIV/REM); 0 marks them illegal.
REQ-002 Parameter: DIV_CYCLES, 4, occupancy in cycles of DIV/DIVU/REM/REMU (range 1..32).
REQ-003 Parameter: ALUCTRL_W, 5, width of alu_ctrl_o (range 5..8).
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: instr_i  in  32  instruction word from IF/ID.
REQ-007 Port: in_valid_i / in_ready_o  in/out  1  upstream handshake.
REQ-008 Port: out_valid_o / out_ready_i  out/in  1  downstream (ID/EX) handshake.
REQ-009 Port: flush_i  in  1  kill the held and in-flight instruction.
REQ-010 Port: reg_write_o, mem_write_o, branch_o, jump_o, jalr_o, alu_src_o  out  1 each  registered control bits.
REQ-011 Port: result_src_o  out  2  00 ALU, 01 memory, 10 PC+4.
REQ-012 Port: imm_src_o  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-013 Port: alu_ctrl_o  out  ALUCTRL_W  ALU operation code, zero-extended.
REQ-014 Port: illegal_o, mdu_busy_o  out  1 each  illegal-instruction flag; divide in progress.

Function
REQ-015 Decoding SHALL use opcode, funct3 and the full funct7; handshake transfer = valid & ready on the same edge.
REQ-016 in_ready_o SHALL be (state==IDLE) & (!out_valid_o | out_ready_i), combinationally.
REQ-017 An accepted non-divide instruction SHALL appear on registered outputs with out_valid_o=1 the next cycle (latency 1).
REQ-018 out_valid_o with its bundle SHALL hold unchanged while out_ready_i=0; it SHALL clear after a transfer with no new accept.
REQ-019 Opcodes: LW 0000011, SW 0100011, R 0110011, I-ALU 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-020 ALU codes: ADD 0, SUB 1, MUL 2, DIV 3, REM 4, SLL 5, SRL 6, SRA 7, AND 8, OR 9, XOR 10, SLT 11, SLTU 12, DIVU 13, REMU 14, LUI 16, AUIPC 17.
REQ-021 I-ALU SHALL decode funct3 exactly like R-type; SRAI/SRA selected by instr_i[30]; SLLI/SRLI/SRAI with other funct7 bits set are illegal.
REQ-022 Branches: BEQ/BNE -> SUB, BLT/BGE -> SLT, BLTU/BGEU -> SLTU; funct3 010/011 illegal.
REQ-023 JAL/JALR: reg_write=1, result_src=10, jump=1; JALR also jalr=1, alu_src=1, imm I, ALU ADD.
REQ-024 LUI/AUIPC: reg_write=1, alu_src=1, imm U, result_src=00; every output field SHALL be fully defined for every opcode (no X).
REQ-025 Unknown opcode, illegal funct field, or M-op with ENABLE_M=0: out_valid_o=1, illegal_o=1, reg_write/mem_write/branch/jump/jalr=0.
REQ-026 FSM states IDLE, MDU_WAIT; accepted DIV/DIVU/REM/REMU (ENABLE_M=1) SHALL go MDU_WAIT with 5-bit counter loaded DIV_CYCLES-1, bundle captured, out_valid_o=0.
REQ-027 In MDU_WAIT: mdu_busy_o=1, in_ready_o=0, counter decrements each cycle; at counter==0 out_valid_o=1 next cycle, state IDLE.
REQ-028 DIV_CYCLES=1 SHALL behave as latency 1 identical to REQ-017 apart from one mdu_busy_o cycle.
REQ-029 MUL SHALL not enter MDU_WAIT.
REQ-030 flush_i SHALL on the next edge clear out_valid_o, illegal_o, mdu_busy_o, return to IDLE and discard any same-cycle accept (flush beats accept).

Reset
REQ-031 While rst_n=0: all outputs 0 (in_ready_o=1 by REQ-016), state IDLE, counter 0, asynchronously.
REQ-032 Reset asserted mid-MDU_WAIT SHALL abort the divide with no output on deassertion.

Structure
REQ-033 Package decode_pkg SHALL hold the opcode constants, the alu_op_e enum (REQ-020), imm_src/result_src codes and state_e.
REQ-034 Combinational decode SHALL live in sub-module ctrl_decode_comb; decode_ctrl_stage holds the FSM, counter and output registers.

Verification
REQ-035 ADD x1,x2,x3 (0x003100B3), out_ready_i=1 -> next cycle out_valid_o=1, alu_ctrl=0, reg_write=1, alu_src=0.
REQ-036 SRAI x5,x6,3 (0x40335293) -> alu_ctrl=7, alu_src=1, imm_src=000; same word with bit 25 set -> illegal_o=1, reg_write=0.
REQ-037 DIV x1,x2,x3 (0x023140B3), DIV_CYCLES=4 -> mdu_busy_o=1 and in_ready_o=0 for 4 cycles, out_valid_o=1 with alu_ctrl=3 on cycle 5.
REQ-038 out_ready_i=0 for 3 cycles holding BEQ (0x00208463) -> bundle stable (branch=1, alu_ctrl=1, imm_src=010), in_ready_o=0.
REQ-039 flush_i pulsed in 2nd MDU_WAIT cycle with in_valid_i=1 -> no output, IDLE, in_ready_o=1 next cycle.
REQ-040 rst_n dropped mid-divide, asynchronously -> all outputs 0 immediately; opcode 1111111 after release -> illegal_o=1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode/control stage.
//   - RV32I/M opcode constants
//   - alu_op_e: ALU operation codes driven onto alu_ctrl_o
//   - immediate-format and result-source codes
//   - state_e: stage FSM states
//   - ctrl_t: one decoded control bundle
//   - base_alu_op(): funct3 -> ALU op for the plain (funct7 = 0) R/I rows
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_MUL   = 5'd2,
        ALU_DIV   = 5'd3,
        ALU_REM   = 5'd4,
        ALU_SLL   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_AND   = 5'd8,
        ALU_OR    = 5'd9,
        ALU_XOR   = 5'd10,
        ALU_SLT   = 5'd11,
        ALU_SLTU  = 5'd12,
        ALU_DIVU  = 5'd13,
        ALU_REMU  = 5'd14,
        ALU_LUI   = 5'd16,
        ALU_AUIPC = 5'd17
    } alu_op_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic {
        IDLE     = 1'b0,
        MDU_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        alu_op_e    alu_op;
        logic       illegal;
    } ctrl_t;

    // Shared by R-type (funct7 = 0) and I-ALU rows.
    function automatic alu_op_e base_alu_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Handshake and control bundle between IF/ID, the decode stage and ID/EX.
//   master : the side feeding instructions and consuming the bundle
//   slave  : the decode stage itself
// Signals: instr_i, in_valid_i/in_ready_o (upstream), out_valid_o/out_ready_i
// (downstream), flush_i, and the registered control outputs.
interface decode_ctrl_stage_if #(
    parameter int ALUCTRL_W = 5
);
    logic [31:0]          instr_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 flush_i;
    logic                 reg_write_o;
    logic                 mem_write_o;
    logic                 branch_o;
    logic                 jump_o;
    logic                 jalr_o;
    logic                 alu_src_o;
    logic [1:0]           result_src_o;
    logic [2:0]           imm_src_o;
    logic [ALUCTRL_W-1:0] alu_ctrl_o;
    logic                 illegal_o;
    logic                 mdu_busy_o;

    modport master (
        output instr_i, in_valid_i, out_ready_i, flush_i,
        input  in_ready_o, out_valid_o, reg_write_o, mem_write_o, branch_o,
               jump_o, jalr_o, alu_src_o, result_src_o, imm_src_o,
               alu_ctrl_o, illegal_o, mdu_busy_o
    );

    modport slave (
        input  instr_i, in_valid_i, out_ready_i, flush_i,
        output in_ready_o, out_valid_o, reg_write_o, mem_write_o, branch_o,
               jump_o, jalr_o, alu_src_o, result_src_o, imm_src_o,
               alu_ctrl_o, illegal_o, mdu_busy_o
    );
endinterface

// File: rtl/ctrl_decode_comb.sv
// Purely combinational RV32I(+M) control decoder.
//   instr_i : instruction word
//   ctrl_o  : decoded control bundle; on any illegal encoding every field is
//             zero except illegal
//   is_div_o: DIV/DIVU/REM/REMU, which need the multi-cycle path
module ctrl_decode_comb
    import decode_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        is_div_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;
    logic       div;
    ctrl_t      c;
    logic       unused_fields;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];
    // Register indices and immediate bits are not needed for control.
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        c          = '0;
        c.alu_op   = ALU_ADD;
        bad        = 1'b0;
        div        = 1'b0;
        case (opcode)
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.result_src = RES_MEM;
                c.imm_src    = IMM_I;
                bad          = (f3 != 3'b010);
            end
            OP_STORE: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.imm_src   = IMM_S;
                bad         = (f3 != 3'b010);
            end
            OP_R: begin
                c.reg_write = 1'b1;
                if (f7 == F7_BASE) begin
                    c.alu_op = base_alu_op(f3);
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        3'b000:  c.alu_op = ALU_SUB;
                        3'b101:  c.alu_op = ALU_SRA;
                        default: bad = 1'b1;
                    endcase
                end else if (f7 == F7_MUL && ENABLE_M != 0) begin
                    // MULH* have no ALU code, so only the low-word multiply
                    // and the four divide/remainder forms are legal.
                    case (f3)
                        3'b000:  c.alu_op = ALU_MUL;
                        3'b100:  begin c.alu_op = ALU_DIV;  div = 1'b1; end
                        3'b101:  begin c.alu_op = ALU_DIVU; div = 1'b1; end
                        3'b110:  begin c.alu_op = ALU_REM;  div = 1'b1; end
                        3'b111:  begin c.alu_op = ALU_REMU; div = 1'b1; end
                        default: bad = 1'b1;
                    endcase
                end else begin
                    bad = 1'b1;
                end
            end
            OP_IMM: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.imm_src   = IMM_I;
                c.alu_op    = base_alu_op(f3);
                // Only the shift forms constrain the upper immediate bits.
                if (f3 == 3'b001) begin
                    bad = (f7 != F7_BASE);
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_ALT)       c.alu_op = ALU_SRA;
                    else if (f7 != F7_BASE) bad = 1'b1;
                end
            end
            OP_BRANCH: begin
                c.branch  = 1'b1;
                c.imm_src = IMM_B;
                case (f3[2:1])
                    2'b00:   c.alu_op = ALU_SUB;
                    2'b10:   c.alu_op = ALU_SLT;
                    2'b11:   c.alu_op = ALU_SLTU;
                    default: bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                c.reg_write  = 1'b1;
                c.jump       = 1'b1;
                c.result_src = RES_PC4;
                c.imm_src    = IMM_J;
            end
            OP_JALR: begin
                c.reg_write  = 1'b1;
                c.jump       = 1'b1;
                c.jalr       = 1'b1;
                c.alu_src    = 1'b1;
                c.result_src = RES_PC4;
                c.imm_src    = IMM_I;
                bad          = (f3 != 3'b000);
            end
            OP_LUI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.imm_src   = IMM_U;
                c.alu_op    = ALU_LUI;
            end
            OP_AUIPC: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.imm_src   = IMM_U;
                c.alu_op    = ALU_AUIPC;
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            c         = '0;
            c.alu_op  = ALU_ADD;
            c.illegal = 1'b1;
            div       = 1'b0;
        end
        ctrl_o   = c;
        is_div_o = div;
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Decode/control pipeline stage between IF/ID and ID/EX.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decode_ctrl_stage_if.slave -- upstream handshake + instr_i,
//                downstream handshake, flush_i and the registered bundle
// Ordinary instructions appear one cycle after acceptance. Divides park the
// stage in MDU_WAIT for DIV_CYCLES cycles before presenting their bundle.
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter int ENABLE_M   = 1,
    parameter int DIV_CYCLES = 4,
    parameter int ALUCTRL_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_ctrl_stage_if.slave   bus
);

    localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

    state_e     state_q, state_d;
    logic [4:0] cnt_q;
    ctrl_t      out_q;
    logic       out_valid_q;
    ctrl_t      dec;
    logic       dec_div;
    logic       in_ready;
    logic       accept;

    ctrl_decode_comb #(
        .ENABLE_M (ENABLE_M)
    ) u_dec (
        .instr_i  (bus.instr_i),
        .ctrl_o   (dec),
        .is_div_o (dec_div)
    );

    // Flush wins over a same-cycle accept.
    assign accept = bus.in_valid_i & in_ready & ~bus.flush_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (accept && dec_div) state_d = MDU_WAIT;
                MDU_WAIT: if (cnt_q == 5'd0)     state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        in_ready       = (state_q == IDLE) & (~out_valid_q | bus.out_ready_i);
        bus.mdu_busy_o = (state_q == MDU_WAIT);
    end

    // Divide counter and output bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 5'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.flush_i) begin
            cnt_q       <= 5'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        // Divides capture their bundle now but hold it
                        // invisible until the counter expires.
                        out_q       <= dec;
                        out_valid_q <= ~dec_div;
                        if (dec_div) cnt_q <= DIV_LOAD;
                    end else if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                    end
                end
                MDU_WAIT: begin
                    if (cnt_q == 5'd0) out_valid_q <= 1'b1;
                    else               cnt_q       <= cnt_q - 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.reg_write_o  = out_q.reg_write;
    assign bus.mem_write_o  = out_q.mem_write;
    assign bus.branch_o     = out_q.branch;
    assign bus.jump_o       = out_q.jump;
    assign bus.jalr_o       = out_q.jalr;
    assign bus.alu_src_o    = out_q.alu_src;
    assign bus.result_src_o = out_q.result_src;
    assign bus.imm_src_o    = out_q.imm_src;
    assign bus.alu_ctrl_o   = ALUCTRL_W'(out_q.alu_op);
    assign bus.illegal_o    = out_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
module tb_decode_ctrl_stage;

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic       br;
        logic       jmp;
        logic       jr;
        logic       asrc;
        logic [1:0] rs;
        logic [2:0] imm;
        logic [4:0] alu;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_ctrl_stage_if #(.ALUCTRL_W(5)) bus();

    decode_ctrl_stage #(
        .ENABLE_M   (1),
        .DIV_CYCLES (4),
        .ALUCTRL_W  (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   errs = 0;
    int   checks = 0;
    exp_t q[$];

    function automatic exp_t mk(input logic rw, mw, br, jmp, jr, asrc,
                                input logic [1:0] rs, input logic [2:0] imm,
                                input logic [4:0] alu, input logic ill);
        exp_t e;
        e = '{rw, mw, br, jmp, jr, asrc, rs, imm, alu, ill};
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a = '{bus.reg_write_o, bus.mem_write_o, bus.branch_o, bus.jump_o,
              bus.jalr_o, bus.alu_src_o, bus.result_src_o, bus.imm_src_o,
              bus.alu_ctrl_o, bus.illegal_o};
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: compare every transferred bundle with the queue head.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            checks++;
            a = actual();
            if (q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_output: got bundle %h expected none", a);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    errs++;
                    $display("FAIL bundle: got %h expected %h", a, e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] ins, input exp_t e, input bit push, input bit is_div);
        int n;
        n = 0;
        bus.instr_i    = ins;
        bus.in_valid_i = 1'b1;
        while (!bus.in_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        if (push) q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        if (is_div) begin
            chk("div_busy_start", 32'(bus.mdu_busy_o), 32'd1);
            chk("div_no_valid", 32'(bus.out_valid_o), 32'd0);
        end else begin
            chk("latency1_valid", 32'(bus.out_valid_o), 32'd1);
            chk("no_busy", 32'(bus.mdu_busy_o), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    localparam int NV = 15;
    logic [31:0] vw [NV];
    exp_t        ve [NV];

    initial begin
        exp_t zero_ill;
        exp_t div_e;
        zero_ill = mk(0,0,0,0,0,0,2'd0,3'd0,5'd0,1);
        div_e    = mk(1,0,0,0,0,0,2'd0,3'd0,5'd3,0);

        vw[0]  = 32'h003100B3; ve[0]  = mk(1,0,0,0,0,0,2'd0,3'd0,5'd0,0);  // ADD
        vw[1]  = 32'h403100B3; ve[1]  = mk(1,0,0,0,0,0,2'd0,3'd0,5'd1,0);  // SUB
        vw[2]  = 32'h40335293; ve[2]  = mk(1,0,0,0,0,1,2'd0,3'd0,5'd7,0);  // SRAI
        vw[3]  = 32'h42335293; ve[3]  = zero_ill;                          // SRAI bad f7
        vw[4]  = 32'h00514093; ve[4]  = mk(1,0,0,0,0,1,2'd0,3'd0,5'd10,0); // XORI
        vw[5]  = 32'h00012083; ve[5]  = mk(1,0,0,0,0,1,2'd1,3'd0,5'd0,0);  // LW
        vw[6]  = 32'h00112023; ve[6]  = mk(0,1,0,0,0,1,2'd0,3'd1,5'd0,0);  // SW
        vw[7]  = 32'h00216463; ve[7]  = mk(0,0,1,0,0,0,2'd0,3'd2,5'd12,0); // BLTU
        vw[8]  = 32'h00202463; ve[8]  = zero_ill;                          // branch f3=010
        vw[9]  = 32'h000000EF; ve[9]  = mk(1,0,0,1,0,0,2'd2,3'd3,5'd0,0);  // JAL
        vw[10] = 32'h000100E7; ve[10] = mk(1,0,0,1,1,1,2'd2,3'd0,5'd0,0);  // JALR
        vw[11] = 32'h123450B7; ve[11] = mk(1,0,0,0,0,1,2'd0,3'd4,5'd16,0); // LUI
        vw[12] = 32'h00000097; ve[12] = mk(1,0,0,0,0,1,2'd0,3'd4,5'd17,0); // AUIPC
        vw[13] = 32'h023100B3; ve[13] = mk(1,0,0,0,0,0,2'd0,3'd0,5'd2,0);  // MUL
        vw[14] = 32'h0000007F; ve[14] = zero_ill;                          // bad opcode

        bus.instr_i     = 32'h0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        bus.flush_i     = 1'b0;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst_busy", 32'(bus.mdu_busy_o), 32'd0);
        chk("rst_bundle", 32'(actual()), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Back-to-back directed vectors
        for (int i = 0; i < NV; i++) send(vw[i], ve[i], 1'b1, 1'b0);
        idle(1);
        chk("valid_clears", 32'(bus.out_valid_o), 32'd0);

        // Divide: 4 busy cycles, output on the 5th
        send(32'h023140B3, div_e, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("div_busy", 32'(bus.mdu_busy_o), 32'd1);
            chk("div_in_ready", 32'(bus.in_ready_o), 32'd0);
            chk("div_valid_low", 32'(bus.out_valid_o), 32'd0);
            idle(1);
        end
        chk("div_valid", 32'(bus.out_valid_o), 32'd1);
        chk("div_alu", 32'(bus.alu_ctrl_o), 32'd3);
        chk("div_busy_end", 32'(bus.mdu_busy_o), 32'd0);
        idle(1);

        // Downstream stall holds BEQ
        bus.out_ready_i = 1'b0;
        send(32'h00208463, mk(0,0,1,0,0,0,2'd0,3'd2,5'd1,0), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(bus.out_valid_o), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready_o), 32'd0);
            chk("stall_branch", 32'(bus.branch_o), 32'd1);
            chk("stall_alu", 32'(bus.alu_ctrl_o), 32'd1);
            chk("stall_imm", 32'(bus.imm_src_o), 32'd2);
            idle(1);
        end
        bus.out_ready_i = 1'b1;
        idle(1);
        chk("stall_release", 32'(bus.out_valid_o), 32'd0);

        // Flush beats a same-cycle accept in IDLE
        bus.flush_i = 1'b1; bus.in_valid_i = 1'b1; bus.instr_i = 32'h003100B3;
        idle(1);
        bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
        chk("flush_idle_valid", 32'(bus.out_valid_o), 32'd0);

        // Flush in the second MDU_WAIT cycle
        send(32'h023140B3, div_e, 1'b0, 1'b1);
        idle(1);
        bus.flush_i = 1'b1; bus.in_valid_i = 1'b1; bus.instr_i = 32'h003100B3;
        idle(1);
        bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
        chk("flush_valid", 32'(bus.out_valid_o), 32'd0);
        chk("flush_busy", 32'(bus.mdu_busy_o), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("flush_illegal", 32'(bus.illegal_o), 32'd0);
        idle(6);

        // Asynchronous reset mid-divide
        send(32'h023140B3, div_e, 1'b0, 1'b1);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.mdu_busy_o), 32'd0);
        chk("arst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("arst_bundle", 32'(actual()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(6);
        chk("arst_no_resume", 32'(bus.mdu_busy_o), 32'd0);
        send(32'h0000007F, zero_ill, 1'b1, 1'b0);
        chk("post_rst_illegal", 32'(bus.illegal_o), 32'd1);
        idle(2);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
